// File: rtl/phys_reg_free_list.sv
// Physical register free list: circular buffer of free tags with show-ahead allocation,
// commit-side returns, a single head checkpoint for branch recovery and a sticky overflow flag.
module phys_reg_free_list #(
    parameter int TAG_W     = 6,
    parameter int NUM_AREGS = 32,
    parameter int DEPTH     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alloc_req,
    output logic             alloc_valid,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic             free_valid,
    input  logic [TAG_W-1:0] free_tag,
    input  logic             ckpt_save,
    input  logic             ckpt_restore,
    output logic [TAG_W-1:0] count,
    output logic             overflow_err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
    localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(DEPTH);

    logic [TAG_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W-1:0] snap_q, snap_d;
    logic             ovf_q, ovf_d;
    logic [PTR_W-1:0] count_s;
    logic [PTR_W-1:0] count_after_pop_s;
    logic             pop_s;
    logic             push_s;

    // Next-state: a restore discards any same-cycle pop; push sees the count after that pop.
    always_comb begin
        count_s           = tail_q - head_q;
        pop_s             = alloc_req && (count_s != {PTR_W{1'b0}}) && !ckpt_restore;
        count_after_pop_s = count_s - (pop_s ? PTR_ONE : {PTR_W{1'b0}});
        push_s            = free_valid && (count_after_pop_s != PTR_FULL);

        if (ckpt_restore) begin
            head_d = snap_q;
        end else if (pop_s) begin
            head_d = head_q + PTR_ONE;
        end else begin
            head_d = head_q;
        end

        if (push_s) begin
            tail_d = tail_q + PTR_ONE;
        end else begin
            tail_d = tail_q;
        end

        // Snapshot takes the post-update head so a same-cycle pop is included.
        if (ckpt_save && !ckpt_restore) begin
            snap_d = head_d;
        end else begin
            snap_d = snap_q;
        end

        ovf_d = ovf_q || (free_valid && !push_s);
    end

    // Pointer, snapshot and error state; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q <= {PTR_W{1'b0}};
            tail_q <= PTR_FULL;
            snap_q <= {PTR_W{1'b0}};
            ovf_q  <= 1'b0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            snap_q <= snap_d;
            ovf_q  <= ovf_d;
        end
    end

    // Tag storage, preloaded with every non-architectural tag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= TAG_W'(NUM_AREGS + i);
            end
        end else if (push_s) begin
            mem_q[tail_q[IDX_W-1:0]] <= free_tag;
        end else begin
            mem_q <= mem_q;
        end
    end

    assign alloc_valid  = (count_s != {PTR_W{1'b0}});
    assign alloc_tag    = mem_q[head_q[IDX_W-1:0]];
    assign count        = TAG_W'(count_s);
    assign overflow_err = ovf_q;

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Self-checking bench for phys_reg_free_list: directed corner cases plus randomized traffic
// against a model that tracks the list as an unbounded sequence of tags with integer positions.
module tb_phys_reg_free_list;

    logic       clk;
    logic       reset;
    logic       alloc_req;
    logic       alloc_valid;
    logic [5:0] alloc_tag;
    logic       free_valid;
    logic [5:0] free_tag;
    logic       ckpt_save;
    logic       ckpt_restore;
    logic [5:0] count;
    logic       overflow_err;

    int n_cmp;
    int n_err;

    // Model: seq holds every tag ever placed in the list, in order; positions never wrap.
    int seq[$];
    int m_head;
    int m_snap;
    bit m_ovf;

    phys_reg_free_list #(.TAG_W(6), .NUM_AREGS(32), .DEPTH(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .alloc_req    (alloc_req),
        .alloc_valid  (alloc_valid),
        .alloc_tag    (alloc_tag),
        .free_valid   (free_valid),
        .free_tag     (free_tag),
        .ckpt_save    (ckpt_save),
        .ckpt_restore (ckpt_restore),
        .count        (count),
        .overflow_err (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int m_cnt();
        return seq.size() - m_head;
    endfunction

    task automatic model_reset();
        seq.delete();
        for (int i = 0; i < 32; i++) seq.push_back(32 + i);
        m_head = 0;
        m_snap = 0;
        m_ovf  = 1'b0;
    endtask

    task automatic model_step(input bit req, input bit fv, input int tg, input bit sv, input bit rs);
        int cnt;
        bit pop;
        bit push;
        cnt  = m_cnt();
        pop  = req && (cnt != 0) && !rs;
        push = fv && ((cnt - int'(pop)) != 32);
        if (fv && !push) m_ovf = 1'b1;
        if (rs) m_head = m_snap;
        else    m_head = m_head + int'(pop);
        if (push) seq.push_back(tg);
        if (sv && !rs) m_snap = m_head;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, alloc_valid, (m_cnt() != 0));
        chk({tag, ".count"}, count, m_cnt());
        chk({tag, ".ovf"}, overflow_err, m_ovf);
        if (m_cnt() != 0) chk({tag, ".tag"}, alloc_tag, seq[m_head]);
    endtask

    // Called at a negedge; drives one cycle of inputs and returns at the following negedge.
    task automatic step(input bit req, input bit fv, input logic [5:0] tg, input bit sv, input bit rs);
        alloc_req    = req;
        free_valid   = fv;
        free_tag     = tg;
        ckpt_save    = sv;
        ckpt_restore = rs;
        model_step(req, fv, int'(tg), sv, rs);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        alloc_req    = 1'b0;
        free_valid   = 1'b0;
        free_tag     = 6'd0;
        ckpt_save    = 1'b0;
        ckpt_restore = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        @(negedge clk);
        do_reset();
        check_all("rst");
        chk("rst.count32", count, 32'd32);
        chk("rst.tag32", alloc_tag, 32'd32);

        // Drain the whole list in order.
        for (int i = 0; i < 32; i++) begin
            chk("drain.order", alloc_tag, 32 + i);
            step(1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
        end
        check_all("drained");
        chk("drained.valid0", alloc_valid, 32'd0);

        // Allocation requests on an empty list do nothing.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
            check_all("empty_req");
        end

        // Return into an empty list: visible only from the next cycle.
        chk("bypass.valid0", alloc_valid, 32'd0);
        step(1'b0, 1'b1, 6'd7, 1'b0, 1'b0);
        check_all("bypass");
        chk("bypass.tag7", alloc_tag, 32'd7);

        // Overflow when full; sticky; legal when paired with a pop.
        do_reset();
        step(1'b0, 1'b1, 6'd5, 1'b0, 1'b0);
        check_all("ovf");
        chk("ovf.set", overflow_err, 32'd1);
        step(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
        check_all("ovf_sticky");
        do_reset();
        step(1'b1, 1'b1, 6'd5, 1'b0, 1'b0);
        check_all("full_poppush");
        chk("full_poppush.ovf0", overflow_err, 32'd0);

        // Checkpoint save and restore with competing pop and push.
        do_reset();
        step(1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 6'd0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
        chk("ckpt.tag37", alloc_tag, 32'd37);
        step(1'b1, 1'b1, 6'd9, 1'b0, 1'b1);
        check_all("restore");
        chk("restore.tag34", alloc_tag, 32'd34);
        chk("restore.count31", count, 32'd31);

        // Asynchronous reset in the middle of an allocation burst.
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
        alloc_req = 1'b1;
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("async_rst.count", count, 32'd32);
        chk("async_rst.tag", alloc_tag, 32'd32);
        chk("async_rst.valid", alloc_valid, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        alloc_req = 1'b0;
        check_all("async_rst_rel");

        // Randomized traffic; a restore is only issued while the snapshot region is intact.
        for (int c = 0; c < 1600; c++) begin
            bit req, fv, sv, rs;
            logic [5:0] tg;
            if ((c % 400) == 399) do_reset();
            req = ($urandom_range(0, 99) < 55);
            fv  = ($urandom_range(0, 99) < 50);
            sv  = ($urandom_range(0, 99) < 10);
            rs  = ($urandom_range(0, 99) < 8);
            tg  = 6'($urandom_range(0, 63));
            if ((seq.size() + int'(fv)) > (m_snap + 32)) rs = 1'b0;
            step(req, fv, tg, sv, rs);
            check_all("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
